// File: rtl/controle_varredura_display_if.sv
// Display-scan bus: load/config inputs toward the scanner, decoder/anode drive back.
interface controle_varredura_display_if #(
  parameter int N_DIGITOS = 4
);
  localparam int IW = $clog2(N_DIGITOS);

  logic                   carregar;
  logic [4*N_DIGITOS-1:0] dados;
  logic                   supressao_zeros;
  logic [3:0]             codigo_BCD;
  logic [N_DIGITOS-1:0]   anodos;
  logic [IW-1:0]          digito_atual;
  logic                   fim_quadro;

  modport master (
    output carregar, dados, supressao_zeros,
    input  codigo_BCD, anodos, digito_atual, fim_quadro
  );

  modport slave (
    input  carregar, dados, supressao_zeros,
    output codigo_BCD, anodos, digito_atual, fim_quadro
  );
endinterface

// File: rtl/controle_varredura_display.sv
// Multiplexed common-anode display scanner sharing one BCD-to-7-segment decoder.
// Double-buffered value, per-slot anti-ghost blank, optional leading-zero blanking.
module controle_varredura_display #(
  parameter int N_DIGITOS   = 4,
  parameter int DIV_REFRESH = 50000,
  parameter int T_APAGADO   = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  controle_varredura_display_if.slave     bus
);
  localparam int IW = $clog2(N_DIGITOS);
  localparam int DW = $clog2(DIV_REFRESH);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_REFRESH - 1);
  localparam logic [DW-1:0] T_AP    = DW'(T_APAGADO);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITOS - 1);

  logic [DW-1:0]          div;
  logic [IW-1:0]          idx;
  logic [4*N_DIGITOS-1:0] sombra;
  logic [4*N_DIGITOS-1:0] ativo;
  logic                   pendente;

  logic                   fim_slot;
  logic                   fim;
  logic [N_DIGITOS-1:0]   zeros_acima;
  logic                   acc;
  logic [3:0]             digito;
  logic                   suprimivel;

  assign fim_slot = (div == DIV_MAX);
  assign fim      = fim_slot && (idx == IDX_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      div      <= '0;
      idx      <= '0;
      sombra   <= '0;
      ativo    <= '0;
      pendente <= 1'b0;
    end else begin
      div <= fim_slot ? '0 : div + 1'b1;
      if (fim_slot)
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      // A load on the frame-end cycle bypasses the shadow so the newest value wins.
      if (bus.carregar) begin
        sombra <= bus.dados;
        if (fim) begin
          ativo    <= bus.dados;
          pendente <= 1'b0;
        end else begin
          pendente <= 1'b1;
        end
      end else if (fim && pendente) begin
        ativo    <= sombra;
        pendente <= 1'b0;
      end
    end
  end

  // zeros_acima[i]: digit i and every more-significant digit are exactly zero.
  always_comb begin
    zeros_acima = '0;
    acc         = 1'b1;
    for (int unsigned k = 0; k < N_DIGITOS; k++) begin
      acc = acc & (ativo[4*(N_DIGITOS-1-k) +: 4] == 4'h0);
      zeros_acima[N_DIGITOS-1-k] = acc;
    end
  end

  always_comb begin
    digito     = 4'h0;
    suprimivel = 1'b0;
    for (int unsigned i = 0; i < N_DIGITOS; i++) begin
      if (idx == IW'(i)) begin
        digito     = ativo[4*i +: 4];
        suprimivel = zeros_acima[i] && (i != 0);
      end
    end
  end

  always_comb begin
    bus.anodos     = '1;
    bus.codigo_BCD = 4'hF;
    if (div >= T_AP) begin
      bus.anodos[idx] = 1'b0;
      if (!(bus.supressao_zeros && suprimivel))
        bus.codigo_BCD = digito;
    end
  end

  assign bus.digito_atual = idx;
  assign bus.fim_quadro   = fim;
endmodule

// File: tb/tb_controle_varredura_display.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, monitor compares on each cycle.
module tb_controle_varredura_display;
  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int TAP = 2;

  typedef struct {
    int         c;
    logic [3:0] an;
    logic [3:0] code;
    logic [1:0] dig;
    logic       fim;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   done  = 1'b0;
  exp_t q[$];
  exp_t e;

  controle_varredura_display_if #(.N_DIGITOS(N)) bus ();

  controle_varredura_display #(
    .N_DIGITOS  (N),
    .DIV_REFRESH(DIV),
    .T_APAGADO  (TAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Cycle index since reset: 0 is the first cycle with the post-reset state.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c != cyc) begin
        failures++;
        $display("FAIL missed_cycle expected_at=%0d now=%0d", e.c, cyc);
      end else if ({bus.anodos, bus.codigo_BCD, bus.digito_atual, bus.fim_quadro} !==
                   {e.an, e.code, e.dig, e.fim}) begin
        failures++;
        $display("FAIL scan cyc=%0d got an=%b code=%h dig=%0d fim=%b want an=%b code=%h dig=%0d fim=%b",
                 cyc, bus.anodos, bus.codigo_BCD, bus.digito_atual, bus.fim_quadro,
                 e.an, e.code, e.dig, e.fim);
      end
    end
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL leftover_expectations got=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic push_slot(input int base, input int d, input logic [3:0] code,
                           input bit fim_last, input int n);
    exp_t x;
    logic [3:0] an_vis;
    an_vis = 4'b1111;
    an_vis[d] = 1'b0;
    for (int k = 0; k < n; k++) begin
      x.c   = base + k;
      x.dig = 2'(d);
      x.fim = fim_last && (k == DIV - 1);
      if (k < TAP) begin
        x.an   = 4'b1111;
        x.code = 4'hF;
      end else begin
        x.an   = an_vis;
        x.code = code;
      end
      q.push_back(x);
    end
  endtask

  // shown: the code expected on each digit (F where suppressed), digit 0 in low nibble.
  task automatic push_frame(input int base, input logic [15:0] shown);
    for (int d = 0; d < N; d++)
      push_slot(base + DIV*d, d, shown[4*d +: 4], d == N-1, DIV);
  endtask

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    @(posedge clock); #1;
    while (cyc != k) begin
      guard++;
      if (guard > 300) begin
        $display("FAIL wait_timeout got_cyc=%0d want_cyc=%0d", cyc, k);
        $fatal(1);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic pulse(input int k, input logic [15:0] d);
    wait_cyc(k);
    bus.carregar = 1'b1;
    bus.dados    = d;
    @(posedge clock); #1;
    bus.carregar = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with reset still asserted.
  task automatic start_reset();
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic finish_test(input int last);
    wait_cyc(last);
    @(negedge clock); #1;
  endtask

  initial begin
    bus.carregar        = 1'b0;
    bus.dados           = '0;
    bus.supressao_zeros = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Idle scan after reset
    start_reset();
    push_frame(0,  16'h0000);
    push_frame(32, 16'h0000);
    reset = 1'b0;
    finish_test(63);

    // Load mid-frame appears only from the next frame
    start_reset();
    push_frame(0,  16'h0000);
    push_frame(32, 16'h1234);
    reset = 1'b0;
    pulse(5, 16'h1234);
    finish_test(63);

    // Leading-zero suppression
    start_reset();
    bus.supressao_zeros = 1'b1;
    push_frame(0,  16'hFFF0);
    push_frame(32, 16'hFF45);
    push_frame(64, 16'hFFF0);
    push_frame(96, 16'hFA05);
    reset = 1'b0;
    pulse(5,  16'h0045);
    pulse(40, 16'h0000);
    pulse(70, 16'h0A05);
    finish_test(127);
    bus.supressao_zeros = 1'b0;

    // Last load within a frame wins
    start_reset();
    push_frame(0,  16'h0000);
    push_frame(32, 16'h2222);
    reset = 1'b0;
    pulse(10, 16'h1111);
    pulse(20, 16'h2222);
    finish_test(63);

    // Load on the frame-end cycle overrides an older pending value
    start_reset();
    push_frame(0,  16'h0000);
    push_frame(32, 16'h9876);
    push_frame(64, 16'h9876);
    reset = 1'b0;
    pulse(10, 16'h5555);
    pulse(31, 16'h9876);
    finish_test(95);

    // Reset mid-slot discards the pending value
    start_reset();
    push_slot(0, 0, 4'h0, 1'b0, DIV);
    push_slot(8, 1, 4'h0, 1'b0, 6);
    reset = 1'b0;
    pulse(5, 16'h4321);
    wait_cyc(13);
    start_reset();
    push_frame(0,  16'h0000);
    push_frame(32, 16'h0000);
    reset = 1'b0;
    finish_test(63);

    done = 1'b1;
  end
endmodule
